// File: rtl/retire_if.sv
// Retire-stage bus: issued pair from execute, late completions, and the
// commit-side outputs towards the architectural state.
interface retire_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [1:0]             in_valid;
  logic                   in_ready;
  logic [1:0]             in_done;
  logic [1:0]             in_exc;
  logic [1:0]             in_regwrite;
  logic [1:0]             in_hiwrite;
  logic [1:0]             in_lowrite;
  logic [1:0][4:0]        in_destreg;
  logic [1:0][DATA_W-1:0] in_result;
  logic [1:0][DATA_W-1:0] in_hidata;
  logic [1:0][DATA_W-1:0] in_lodata;
  logic [1:0][DATA_W-1:0] in_pc;
  logic [1:0]             cpl_valid;
  logic [1:0][DATA_W-1:0] cpl_data;
  logic [1:0]             rf_wen;
  logic [1:0][4:0]        rf_addr;
  logic [1:0][DATA_W-1:0] rf_wd;
  logic                   hl_wen_h;
  logic                   hl_wen_l;
  logic [DATA_W-1:0]      hl_wd_h;
  logic [DATA_W-1:0]      hl_wd_l;
  logic [1:0]             rt_valid;
  logic [1:0][DATA_W-1:0] rt_pc;
  logic                   exc_valid;
  logic [DATA_W-1:0]      exc_pc;
  logic                   flush;
  logic [CNT_W-1:0]       rt_count;

  // Environment side: execute stage and architectural-state consumers
  modport master (
    output in_valid, in_done, in_exc, in_regwrite, in_hiwrite, in_lowrite,
           in_destreg, in_result, in_hidata, in_lodata, in_pc,
           cpl_valid, cpl_data,
    input  in_ready, rf_wen, rf_addr, rf_wd, hl_wen_h, hl_wen_l, hl_wd_h,
           hl_wd_l, rt_valid, rt_pc, exc_valid, exc_pc, flush, rt_count
  );

  // Retire controller side
  modport slave (
    input  in_valid, in_done, in_exc, in_regwrite, in_hiwrite, in_lowrite,
           in_destreg, in_result, in_hidata, in_lodata, in_pc,
           cpl_valid, cpl_data,
    output in_ready, rf_wen, rf_addr, rf_wd, hl_wen_h, hl_wen_l, hl_wd_h,
           hl_wd_l, rt_valid, rt_pc, exc_valid, exc_pc, flush, rt_count
  );
endinterface

// File: rtl/retire_ctrl.sv
// Retire-stage controller: holds one issued pair, waits for late results,
// commits in program order and raises precise exceptions with a flush.
module retire_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input logic     clk,
  input logic     reset,
  retire_if.slave bus
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]             state;

  // Hold register
  logic [1:0]             h_valid;
  logic [1:0]             h_done;
  logic [1:0]             h_exc;
  logic [1:0]             h_regwrite;
  logic [1:0]             h_hiwrite;
  logic [1:0]             h_lowrite;
  logic [1:0][4:0]        h_destreg;
  logic [1:0][DATA_W-1:0] h_result;
  logic [1:0][DATA_W-1:0] h_hidata;
  logic [1:0][DATA_W-1:0] h_lodata;
  logic [1:0][DATA_W-1:0] h_pc;

  logic [CNT_W-1:0]       cnt_q;

  logic                   commit0;
  logic                   commit1;
  logic                   exc0;
  logic                   exc1;
  logic                   exc_any;
  logic [1:0]             remain;
  logic [1:0]             rt_v;
  logic                   ready;
  logic                   accept;
  logic                   we0;
  logic                   we1;
  logic                   hw0;
  logic                   hw1;
  logic                   lw0;
  logic                   lw1;

  // Commit decision from the hold register; everything is gated off in reset
  always_comb begin
    commit0 = 1'b0;
    commit1 = 1'b0;
    if (!reset && state == S_HOLD) begin
      commit0 = h_valid[0] & h_done[0];
      // Slot 1 needs slot 0 retired (now or earlier) and must not follow an
      // excepting slot 0.
      commit1 = h_valid[1] & h_done[1] & (~h_valid[0] | commit0) &
                ~(commit0 & h_exc[0]);
    end
    exc0    = commit0 & h_exc[0];
    exc1    = commit1 & h_exc[1];
    exc_any = exc0 | exc1;
    remain  = h_valid & ~{commit1, commit0};
    rt_v    = {commit1 & ~h_exc[1], commit0 & ~h_exc[0]};
    ready   = !reset && (state == S_EMPTY ||
                         (state == S_HOLD && !exc_any && remain == 2'b00));
    accept  = bus.in_valid[0] & ready;
  end

  // Register-file and HI/LO write resolution; younger slot wins on conflict
  always_comb begin
    we1 = rt_v[1] & h_regwrite[1] & (h_destreg[1] != 5'd0);
    we0 = rt_v[0] & h_regwrite[0] & (h_destreg[0] != 5'd0) &
          ~(we1 && h_destreg[0] == h_destreg[1]);
    hw0 = rt_v[0] & h_hiwrite[0];
    hw1 = rt_v[1] & h_hiwrite[1];
    lw0 = rt_v[0] & h_lowrite[0];
    lw1 = rt_v[1] & h_lowrite[1];
  end

  // Output drive
  always_comb begin
    bus.in_ready  = ready;
    bus.rf_wen    = {we1, we0};
    bus.rf_addr   = h_destreg;
    bus.rf_wd     = h_result;
    bus.hl_wen_h  = hw0 | hw1;
    bus.hl_wen_l  = lw0 | lw1;
    bus.hl_wd_h   = hw1 ? h_hidata[1] : h_hidata[0];
    bus.hl_wd_l   = lw1 ? h_lodata[1] : h_lodata[0];
    bus.rt_valid  = rt_v;
    bus.rt_pc     = h_pc;
    bus.exc_valid = exc_any;
    bus.exc_pc    = exc0 ? h_pc[0] : h_pc[1];
    bus.flush     = exc_any;
    bus.rt_count  = cnt_q;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(rt_v[0]) + CNT_W'(rt_v[1]);
    end
  end

  // State machine, hold-register control and late-completion capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_EMPTY;
      h_valid <= '0;
      h_done  <= '0;
      h_exc   <= '0;
    end else begin
      case (state)
        S_EMPTY, S_HOLD: begin
          if (state == S_HOLD) begin
            h_valid <= remain;
            for (int unsigned i = 0; i < 2; i++) begin
              if (bus.cpl_valid[i] && h_valid[i] && !h_done[i]) begin
                h_done[i] <= 1'b1;
                if (h_regwrite[i]) begin
                  h_result[i] <= bus.cpl_data[i];
                end
                if (h_hiwrite[i] || h_lowrite[i]) begin
                  h_hidata[i] <= bus.cpl_data[i];
                  h_lodata[i] <= bus.cpl_data[i];
                end
              end
            end
          end
          if (exc_any) begin
            state <= S_FLUSH;
          end else if (accept) begin
            // A new pair overrides whatever the emptying pair left behind
            state      <= S_HOLD;
            h_valid    <= {bus.in_valid[1] & bus.in_valid[0], bus.in_valid[0]};
            h_done     <= bus.in_done | bus.in_exc;
            h_exc      <= bus.in_exc;
            h_regwrite <= bus.in_regwrite;
            h_hiwrite  <= bus.in_hiwrite;
            h_lowrite  <= bus.in_lowrite;
            h_destreg  <= bus.in_destreg;
            h_result   <= bus.in_result;
            h_hidata   <= bus.in_hidata;
            h_lodata   <= bus.in_lodata;
            h_pc       <= bus.in_pc;
          end else if (state == S_HOLD && remain == 2'b00) begin
            state <= S_EMPTY;
          end
        end
        S_FLUSH: begin
          state   <= S_EMPTY;
          h_valid <= '0;
          h_done  <= '0;
          h_exc   <= '0;
        end
        default: begin
          state   <= S_EMPTY;
          h_valid <= '0;
          h_done  <= '0;
          h_exc   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed bench for retire_ctrl: each task drives one scenario and checks
// the combinational commit outputs mid-cycle against hand-computed values.
module tb_retire_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_count;

  retire_if #(.DATA_W(32), .CNT_W(32)) bus ();
  retire_ctrl #(.DATA_W(32), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in;
    bus.in_valid = '0; bus.in_done = '0; bus.in_exc = '0;
    bus.in_regwrite = '0; bus.in_hiwrite = '0; bus.in_lowrite = '0;
    bus.in_destreg = '0; bus.in_result = '0; bus.in_hidata = '0;
    bus.in_lodata = '0; bus.in_pc = '0; bus.cpl_valid = '0; bus.cpl_data = '0;
  endtask

  task automatic set_slot(input int s, input logic d, input logic x,
                          input logic rw, input logic hw, input logic lw,
                          input logic [4:0] dst, input logic [31:0] res,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic [31:0] pc);
    bus.in_valid[s] = 1'b1; bus.in_done[s] = d; bus.in_exc[s] = x;
    bus.in_regwrite[s] = rw; bus.in_hiwrite[s] = hw; bus.in_lowrite[s] = lw;
    bus.in_destreg[s] = dst; bus.in_result[s] = res;
    bus.in_hidata[s] = hi; bus.in_lodata[s] = lo; bus.in_pc[s] = pc;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_in();
    tick(); tick();
    #1;
    checks++; if (bus.rf_wen !== 2'b00 || bus.rt_valid !== 2'b00) begin errors++; $display("FAIL reset_active_commit: rf_wen=%b rt_valid=%b want 00/00", bus.rf_wen, bus.rt_valid); end
    checks++; if (bus.exc_valid !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL reset_active_exc: exc=%b flush=%b want 0/0", bus.exc_valid, bus.flush); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.rt_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.rt_count); end
    checks++; if (bus.rf_wen !== 2'b00 || bus.rt_valid !== 2'b00 || bus.flush !== 1'b0 || bus.hl_wen_h !== 1'b0 || bus.hl_wen_l !== 1'b0) begin errors++; $display("FAIL reset_after_outputs: rf_wen=%b rt_valid=%b flush=%b want all 0", bus.rf_wen, bus.rt_valid, bus.flush); end
    exp_count = 0;
    tick();
  endtask

  task automatic test_alu_pair;
    clear_in();
    set_slot(0, 1, 0, 1, 0, 0, 5'd3, 32'h0000_0033, 0, 0, 32'h0000_1000);
    set_slot(1, 1, 0, 1, 0, 0, 5'd4, 32'h0000_0044, 0, 0, 32'h0000_1004);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", bus.in_ready); end
    tick();
    clear_in();
    #1;
    checks++; if (bus.rf_wen !== 2'b11 || bus.rt_valid !== 2'b11) begin errors++; $display("FAIL alu_commit: rf_wen=%b rt_valid=%b want 11/11", bus.rf_wen, bus.rt_valid); end
    checks++; if (bus.rf_addr[0] !== 5'd3 || bus.rf_addr[1] !== 5'd4 || bus.rf_wd[0] !== 32'h33 || bus.rf_wd[1] !== 32'h44) begin errors++; $display("FAIL alu_data: addr=%0d/%0d wd=%h/%h want 3/4 33/44", bus.rf_addr[0], bus.rf_addr[1], bus.rf_wd[0], bus.rf_wd[1]); end
    checks++; if (bus.rt_pc[0] !== 32'h1000 || bus.rt_pc[1] !== 32'h1004) begin errors++; $display("FAIL alu_pc: got %h/%h want 1000/1004", bus.rt_pc[0], bus.rt_pc[1]); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_empty: got %b want 1", bus.in_ready); end
    tick();
    exp_count = exp_count + 2;
    #1;
    checks++; if (bus.rt_count !== exp_count) begin errors++; $display("FAIL alu_count: got %0d want %0d", bus.rt_count, exp_count); end
  endtask

  task automatic test_load;
    clear_in();
    set_slot(0, 0, 0, 1, 0, 0, 5'd7, 32'h0, 0, 0, 32'h0000_2000);
    set_slot(1, 1, 0, 1, 0, 0, 5'd8, 32'h0000_0088, 0, 0, 32'h0000_2004);
    tick();
    clear_in();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        bus.cpl_valid = 2'b01;
        bus.cpl_data[0] = 32'hDEAD_BEEF;
      end
      #1;
      checks++; if (bus.in_ready !== 1'b0 || bus.rt_valid !== 2'b00) begin errors++; $display("FAIL load_wait_c%0d: ready=%b rt_valid=%b want 0/00", c, bus.in_ready, bus.rt_valid); end
      tick();
    end
    bus.cpl_valid = 2'b00;
    #1;
    checks++; if (bus.rf_wen !== 2'b11 || bus.rt_valid !== 2'b11) begin errors++; $display("FAIL load_commit: rf_wen=%b rt_valid=%b want 11/11", bus.rf_wen, bus.rt_valid); end
    checks++; if (bus.rf_wd[0] !== 32'hDEAD_BEEF || bus.rf_wd[1] !== 32'h88) begin errors++; $display("FAIL load_data: got %h/%h want deadbeef/88", bus.rf_wd[0], bus.rf_wd[1]); end
    tick();
    exp_count = exp_count + 2;
  endtask

  task automatic test_same_dest;
    clear_in();
    set_slot(0, 1, 0, 1, 0, 0, 5'd5, 32'h0000_0111, 0, 0, 32'h3000);
    set_slot(1, 1, 0, 1, 0, 0, 5'd5, 32'h0000_0222, 0, 0, 32'h3004);
    tick();
    // Next pair presented during the commit cycle: slot 0 targets r0
    clear_in();
    set_slot(0, 1, 0, 1, 0, 0, 5'd0, 32'h0000_0999, 0, 0, 32'h3008);
    set_slot(1, 1, 0, 1, 0, 0, 5'd9, 32'h0000_0909, 0, 0, 32'h300C);
    #1;
    checks++; if (bus.rf_wen !== 2'b10 || bus.rt_valid !== 2'b11) begin errors++; $display("FAIL same_dest_wen: rf_wen=%b rt_valid=%b want 10/11", bus.rf_wen, bus.rt_valid); end
    checks++; if (bus.rf_wd[1] !== 32'h222 || bus.rf_addr[1] !== 5'd5) begin errors++; $display("FAIL same_dest_data: got %h r%0d want 222 r5", bus.rf_wd[1], bus.rf_addr[1]); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL same_dest_ready: got %b want 1", bus.in_ready); end
    tick();
    clear_in();
    #1;
    checks++; if (bus.rf_wen !== 2'b10 || bus.rt_valid !== 2'b11) begin errors++; $display("FAIL r0_wen: rf_wen=%b rt_valid=%b want 10/11", bus.rf_wen, bus.rt_valid); end
    tick();
    exp_count = exp_count + 4;
    #1;
    checks++; if (bus.rt_count !== exp_count) begin errors++; $display("FAIL same_dest_count: got %0d want %0d", bus.rt_count, exp_count); end
  endtask

  task automatic test_exc0;
    clear_in();
    set_slot(0, 0, 1, 1, 0, 0, 5'd6, 32'h66, 0, 0, 32'hBFC0_0100);
    set_slot(1, 1, 0, 1, 1, 0, 5'd7, 32'h77, 32'h7, 0, 32'hBFC0_0104);
    tick();
    clear_in();
    #1;
    checks++; if (bus.exc_valid !== 1'b1 || bus.exc_pc !== 32'hBFC0_0100 || bus.flush !== 1'b1) begin errors++; $display("FAIL exc0_report: exc=%b pc=%h flush=%b want 1 bfc00100 1", bus.exc_valid, bus.exc_pc, bus.flush); end
    checks++; if (bus.rf_wen !== 2'b00 || bus.rt_valid !== 2'b00 || bus.hl_wen_h !== 1'b0) begin errors++; $display("FAIL exc0_writes: rf_wen=%b rt_valid=%b hl_h=%b want 00/00/0", bus.rf_wen, bus.rt_valid, bus.hl_wen_h); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL exc0_ready: got %b want 0", bus.in_ready); end
    tick();
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.flush !== 1'b0 || bus.rt_valid !== 2'b00) begin errors++; $display("FAIL exc0_flush_cycle: ready=%b flush=%b rt_valid=%b want 0/0/00", bus.in_ready, bus.flush, bus.rt_valid); end
    checks++; if (bus.rt_count !== exp_count) begin errors++; $display("FAIL exc0_count: got %0d want %0d", bus.rt_count, exp_count); end
    tick();
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL exc0_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_exc1;
    clear_in();
    set_slot(0, 1, 0, 1, 0, 0, 5'd10, 32'h55, 0, 0, 32'h0000_2000);
    set_slot(1, 1, 1, 1, 0, 0, 5'd13, 32'h13, 0, 0, 32'h0000_2004);
    tick();
    clear_in();
    #1;
    checks++; if (bus.rt_valid !== 2'b01 || bus.rf_wen !== 2'b01 || bus.rf_wd[0] !== 32'h55) begin errors++; $display("FAIL exc1_commit: rt_valid=%b rf_wen=%b wd=%h want 01/01/55", bus.rt_valid, bus.rf_wen, bus.rf_wd[0]); end
    checks++; if (bus.exc_valid !== 1'b1 || bus.exc_pc !== 32'h2004 || bus.flush !== 1'b1) begin errors++; $display("FAIL exc1_report: exc=%b pc=%h flush=%b want 1 2004 1", bus.exc_valid, bus.exc_pc, bus.flush); end
    tick();
    exp_count = exp_count + 1;
    #1;
    checks++; if (bus.rt_count !== exp_count || bus.in_ready !== 1'b0) begin errors++; $display("FAIL exc1_count: count=%0d ready=%b want %0d/0", bus.rt_count, bus.in_ready, exp_count); end
    tick();
  endtask

  task automatic test_hilo;
    clear_in();
    set_slot(0, 1, 0, 0, 1, 0, 5'd0, 0, 32'hA0A0_A0A0, 32'h0, 32'h4000);
    set_slot(1, 1, 0, 0, 1, 1, 5'd0, 0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'h4004);
    tick();
    clear_in();
    #1;
    checks++; if (bus.hl_wen_h !== 1'b1 || bus.hl_wd_h !== 32'hB1B1_B1B1) begin errors++; $display("FAIL hilo_hi: wen=%b wd=%h want 1 b1b1b1b1", bus.hl_wen_h, bus.hl_wd_h); end
    checks++; if (bus.hl_wen_l !== 1'b1 || bus.hl_wd_l !== 32'hC2C2_C2C2) begin errors++; $display("FAIL hilo_lo: wen=%b wd=%h want 1 c2c2c2c2", bus.hl_wen_l, bus.hl_wd_l); end
    checks++; if (bus.rf_wen !== 2'b00 || bus.rt_valid !== 2'b11) begin errors++; $display("FAIL hilo_rf: rf_wen=%b rt_valid=%b want 00/11", bus.rf_wen, bus.rt_valid); end
    tick();
    exp_count = exp_count + 2;
  endtask

  task automatic test_partial;
    clear_in();
    set_slot(0, 1, 0, 1, 0, 0, 5'd11, 32'h1111, 0, 0, 32'h5000);
    set_slot(1, 0, 0, 1, 0, 0, 5'd12, 32'h0, 0, 0, 32'h5004);
    tick();
    clear_in();
    #1;
    checks++; if (bus.rt_valid !== 2'b01 || bus.rf_wen !== 2'b01 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL partial_first: rt_valid=%b rf_wen=%b ready=%b want 01/01/0", bus.rt_valid, bus.rf_wen, bus.in_ready); end
    tick();
    bus.cpl_valid = 2'b11;
    bus.cpl_data[0] = 32'h0000_0BAD;
    bus.cpl_data[1] = 32'hCAFE_0001;
    #1;
    checks++; if (bus.rt_valid !== 2'b00 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL partial_wait: rt_valid=%b ready=%b want 00/0", bus.rt_valid, bus.in_ready); end
    tick();
    bus.cpl_valid = 2'b00;
    #1;
    checks++; if (bus.rt_valid !== 2'b10 || bus.rf_wen !== 2'b10 || bus.rf_wd[1] !== 32'hCAFE_0001) begin errors++; $display("FAIL partial_second: rt_valid=%b rf_wen=%b wd=%h want 10/10/cafe0001", bus.rt_valid, bus.rf_wen, bus.rf_wd[1]); end
    checks++; if (bus.in_ready !== 1'b1 || bus.rt_pc[1] !== 32'h5004) begin errors++; $display("FAIL partial_ready: ready=%b pc=%h want 1/5004", bus.in_ready, bus.rt_pc[1]); end
    tick();
    exp_count = exp_count + 2;
    #1;
    checks++; if (bus.rt_count !== exp_count) begin errors++; $display("FAIL partial_count: got %0d want %0d", bus.rt_count, exp_count); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      clear_in();
      set_slot(0, 1, 0, 1, 0, 0, 5'd14, 32'h100 + k, 0, 0, 32'h6000 + 8 * k);
      set_slot(1, 1, 0, 1, 0, 0, 5'd15, 32'h200 + k, 0, 0, 32'h6004 + 8 * k);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", k, bus.in_ready); end
      if (k > 0) begin
        checks++; if (bus.rt_valid !== 2'b11 || bus.rt_pc[0] !== 32'h6000 + 8 * (k - 1)) begin errors++; $display("FAIL b2b_commit_%0d: rt_valid=%b pc=%h want 11/%h", k, bus.rt_valid, bus.rt_pc[0], 32'h6000 + 8 * (k - 1)); end
      end
      tick();
    end
    clear_in();
    #1;
    checks++; if (bus.rt_valid !== 2'b11 || bus.rt_pc[0] !== 32'h6010 || bus.rf_wd[1] !== 32'h202) begin errors++; $display("FAIL b2b_last: rt_valid=%b pc=%h wd=%h want 11/6010/202", bus.rt_valid, bus.rt_pc[0], bus.rf_wd[1]); end
    tick();
    exp_count = exp_count + 6;
    #1;
    checks++; if (bus.rt_count !== exp_count) begin errors++; $display("FAIL b2b_count: got %0d want %0d", bus.rt_count, exp_count); end
  endtask

  task automatic test_reset_mid_hold;
    clear_in();
    set_slot(0, 0, 0, 1, 0, 0, 5'd16, 32'h0, 0, 0, 32'h7000);
    set_slot(1, 1, 0, 1, 0, 0, 5'd17, 32'h17, 0, 0, 32'h7004);
    tick();
    clear_in();
    #1;
    checks++; if (bus.rt_valid !== 2'b00) begin errors++; $display("FAIL midhold_wait: rt_valid=%b want 00", bus.rt_valid); end
    tick();
    reset = 1'b1;
    bus.cpl_valid = 2'b01;
    bus.cpl_data[0] = 32'h1234_5678;
    #1;
    checks++; if (bus.rt_valid !== 2'b00 || bus.rf_wen !== 2'b00) begin errors++; $display("FAIL midhold_in_reset: rt_valid=%b rf_wen=%b want 00/00", bus.rt_valid, bus.rf_wen); end
    tick();
    reset = 1'b0;
    bus.cpl_valid = 2'b00;
    exp_count = 0;
    #1;
    checks++; if (bus.rt_count !== exp_count || bus.in_ready !== 1'b1 || bus.rt_valid !== 2'b00) begin errors++; $display("FAIL midhold_after: count=%0d ready=%b rt_valid=%b want 0/1/00", bus.rt_count, bus.in_ready, bus.rt_valid); end
    tick();
    #1;
    checks++; if (bus.rt_valid !== 2'b00 || bus.rt_count !== exp_count) begin errors++; $display("FAIL midhold_discard: rt_valid=%b count=%0d want 00/0", bus.rt_valid, bus.rt_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = 0;
    reset = 1'b1;
    clear_in();
    @(negedge clk);
    test_reset();
    test_alu_pair();
    test_load();
    test_same_dest();
    test_exc0();
    test_exc1();
    test_hilo();
    test_partial();
    test_back_to_back();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_ctrl.md
# retire_ctrl

Retire-stage controller for the dual-issue in-order pipeline. Holds one issued instruction pair (slot 0 older, slot 1 younger) from execute, waits for late results (loads, multi-cycle HI/LO ops), then commits in program order. Drives the register-file write ports, the HI/LO write port, retire PCs and the precise-exception/flush request. Sits between the execute/memory stage and the architectural state.

## Interface
Parameters:
- DATA_W, 32, datapath width
- CNT_W, 32, retired-instruction counter width

Ports (clock and reset first; per-slot buses are [1:0] arrays, index 0 = older):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  2  slot occupied in presented pair; in_valid[1] implies in_valid[0]
- in_ready  out  1  pair accepted on clk edge when in_valid[0] & in_ready
- in_done  in  2  result already final at issue
- in_exc  in  2  slot raised exception
- in_regwrite, in_hiwrite, in_lowrite  in  2 each  write enables
- in_destreg  in  2x5  destination GPR
- in_result, in_hidata, in_lodata, in_pc  in  2xDATA_W each
- cpl_valid  in  2  late completion for held slot i (one-cycle pulse)
- cpl_data  in  2xDATA_W  late result; replaces result (regwrite) or hidata/lodata (hi/lo op, both words)
- rf_wen  out  2;  rf_addr  out  2x5;  rf_wd  out  2xDATA_W
- hl_wen_h, hl_wen_l  out  1 each;  hl_wd_h, hl_wd_l  out  DATA_W each
- rt_valid  out  2;  rt_pc  out  2xDATA_W  committing slots and their PCs
- exc_valid  out  1;  exc_pc  out  DATA_W  precise exception report
- flush  out  1  pipeline flush request
- rt_count  out  CNT_W  total retired instructions

## Operation
- Hold register: one pair plus per-slot done/exc flags. States: EMPTY, HOLD, FLUSH.
- EMPTY: in_ready=1; on accept, latch pair, done[i]=in_done[i]|in_exc[i] → HOLD.
- HOLD: cpl_valid[i] for a valid, not-done slot sets done[i] and captures cpl_data. Cpl for a done, invalid or absent slot is ignored.
- Commit decision, combinational from hold register each HOLD cycle:
  - slot 0 commits when done[0];
  - slot 1 commits when slot 0 commits (or slot 0 already committed) and done[1].
  - Committed slot clears its valid bit.
  - When all valid slots are clear: return to EMPTY, and in_ready=1 in that same cycle (back-to-back accept allowed).
- Partial commit: slot 0 committed, slot 1 still waiting → stay HOLD with only slot 1 pending; in_ready=0.
- Exception, slot 0 (on commit): no writes from either slot; rt_valid=00; exc_valid=1, exc_pc=pc[0], flush=1 → FLUSH.
- Exception, slot 1: slot 0 commits normally in the same cycle; slot 1 writes suppressed; exc_pc=pc[1]; flush=1 → FLUSH.
- FLUSH: lasts one cycle, in_ready=0, hold cleared → EMPTY.
- Write rules:
  - rf_wen[i]=commit[i] & regwrite & destreg≠0.
  - If both slots write the same nonzero register in one cycle, rf_wen[0] is forced 0 (younger wins).
  - HI and LO are resolved independently: hl_wen_h = OR of committing hiwrite; data from slot 1 if it commits a hiwrite, else slot 0. LO uses the same rule.
- rt_count adds popcount(rt_valid) each cycle and wraps modulo 2^CNT_W. Excepting slots are not counted.

## Timing
- Reset: state EMPTY, hold cleared, in_ready=1 in the cycle after reset, rt_count=0. All write enables, rt_valid, exc_valid and flush are 0 during reset and in the cycle following it.
- Commit outputs are combinational from the hold register; architectural state is updated at the next edge.
- Minimum latency: pair accepted at edge N with both done → commits during cycle N+1.
- A cpl_valid pulse in cycle M allows commit in cycle M+1. It is not forwarded in the same cycle.
- Throughput: one pair per cycle when all results are done.
- Reset asserted mid-HOLD or in FLUSH discards the held pair without any commit.

## Test plan
- Two ALU ops, both done, dest r3 and r4: pair accepted edge 0 → cycle 1 shows rf_wen=11, rt_valid=11, rt_count becomes 2.
- Slot 0 is a load (not done), slot 1 an ALU op: cpl_valid[0] in cycle 4 with 0xDEADBEEF → cycle 5 commits both, rf_wd[0]=0xDEADBEEF. in_ready stays 0 in cycles 1–4.
- Both slots write r5: rf_wen=10, rf_wd[1]=r5 value. A write to r0 → rf_wen bit 0.
- Slot 0 exception, pc 0xBFC00100: exc_valid=1, exc_pc=0xBFC00100, rf_wen=00, flush=1, then in_ready=0 for one cycle.
- Slot 1 exception: slot 0 commits with rt_valid=01, exc_pc=pc[1], rt_count +1.
- Slot 0 is MTHI, slot 1 is MTLO and MTHI: hl_wen_h=1 with hl_wd_h from slot 1, hl_wen_l=1 with data from slot 1. Then reset asserted mid-HOLD → no commit, rt_count=0.
